// File: rtl/rv32_boot_loader.sv
// Framed byte-stream loader: fills instruction memory from word 0, then releases the RV32 core.
// Build option: define BOOT_CHECKSUM_EN to expect and check a trailing XOR checksum byte.
module rv32_boot_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              boot_busy,
    output logic              boot_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;
    localparam int unsigned WL_W      = ADDR_W + 1;
    localparam logic [7:0]  MAGIC     = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_rx_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_core_rst_n;
    logic                r_boot_busy;
    logic                r_boot_err;
    logic [WL_W-1:0]     r_words;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_word_buf;

    logic                w_acc;
    logic [15:0]         w_len_n;
    logic                w_len_bad;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_frame_start;

    assign w_acc         = rx_valid & r_rx_ready;
    assign w_len_n       = {rx_data, r_len[7:0]};
    assign w_len_bad     = (w_len_n == 16'd0) || (32'(w_len_n) > MAX_WORDS);
    assign w_word_done   = (r_byte_cnt == 2'd3);
    assign w_last_word   = ((32'(r_words) + 32'd1) == 32'(r_len));
    assign w_frame_start = w_acc && (rx_data == MAGIC) &&
                           ((r_state == S_IDLE) || (r_state == S_ERROR));

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR over length and data bytes; cleared at every frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= 8'd0;
        end else if (w_frame_start) begin
            r_csum <= 8'd0;
        end else if (w_acc && ((r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA))) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    // Next-state decode; only an accepted byte moves the FSM.
    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            unique case (r_state)
                S_IDLE, S_ERROR: if (rx_data == MAGIC) w_next = S_LEN0;
                S_LEN0:          w_next = S_LEN1;
                S_LEN1:          w_next = w_len_bad ? S_ERROR : S_DATA;
`ifdef BOOT_CHECKSUM_EN
                S_DATA:          if (w_word_done && w_last_word) w_next = S_CSUM;
                S_CSUM:          w_next = ((r_csum ^ rx_data) == 8'd0) ? S_DONE : S_ERROR;
`else
                S_DATA:          if (w_word_done && w_last_word) w_next = S_DONE;
`endif
                default:         w_next = r_state;
            endcase
        end
    end

    // State, registered status outputs, and word assembly / memory write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_boot_busy  <= 1'b0;
            r_boot_err   <= 1'b0;
            r_words      <= '0;
            r_len        <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_word_buf   <= 24'd0;
        end else begin
            r_state      <= w_next;
            r_rx_ready   <= (w_next != S_DONE);
            r_core_rst_n <= (w_next == S_DONE);
            r_boot_err   <= (w_next == S_ERROR);
            r_boot_busy  <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                            (w_next == S_DATA) || (w_next == S_CSUM);
            r_imem_we    <= 1'b0;
            if (w_frame_start) begin
                r_words    <= '0;
                r_byte_cnt <= 2'd0;
            end
            if (w_acc) begin
                unique case (r_state)
                    S_LEN0: r_len[7:0]  <= rx_data;
                    S_LEN1: r_len[15:8] <= rx_data;
                    S_DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_word_buf <= {rx_data, r_word_buf[23:8]};
                        if (w_word_done) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_words[ADDR_W-1:0];
                            r_imem_wdata <= {rx_data, r_word_buf};
                            r_words      <= r_words + WL_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready     = r_rx_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign core_rst_n   = r_core_rst_n;
    assign boot_busy    = r_boot_busy;
    assign boot_err     = r_boot_err;
    assign words_loaded = r_words;
endmodule

// File: tb/tb_rv32_boot_loader.sv
// Directed self-checking bench for rv32_boot_loader; covers both BOOT_CHECKSUM_EN builds.
`timescale 1ns/1ps
module tb_rv32_boot_loader;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              boot_busy;
    logic              boot_err;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    int                wr_cnt = 0;
    logic [ADDR_W-1:0] wr_addr [0:1023];
    logic [31:0]       wr_data [0:1023];
    logic [31:0]       img     [0:255];

    rv32_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .boot_busy(boot_busy), .boot_err(boot_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every memory write strobe seen during a cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr[wr_cnt] = imem_addr;
            wr_data[wr_cnt] = imem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Present one byte and return one cycle after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (rx_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: rx_ready=%b for byte %h, want 1", rx_ready, b);
        end else begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic send_body(input int n, input bit gaps, output logic [7:0] x);
        logic [15:0] len;
        len = 16'(n);
        x = len[7:0] ^ len[15:8];
        send_byte(8'hA5);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wd;
                logic [7:0]  b;
                wd = img[w];
                b  = wd[8*k +: 8];
                x  = x ^ b;
                if (gaps) idle($urandom_range(0, 3));
                send_byte(b);
            end
        end
    endtask

    task automatic send_frame(input int n, input bit gaps);
        logic [7:0] x;
        send_body(n, gaps, x);
`ifdef BOOT_CHECKSUM_EN
        if (gaps) idle($urandom_range(0, 3));
        send_byte(x);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rst_imem_we: got %b want 0", imem_we); end
        n_cmp++; if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_imem_bus: got %h/%h want 00/00000000", imem_addr, imem_wdata); end
        n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); end
        n_cmp++; if (boot_busy !== 1'b0 || boot_err !== 1'b0) begin n_bad++; $display("FAIL rst_status: busy=%b err=%b want 0/0", boot_busy, boot_err); end
        n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_single_word();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5);
        n_cmp++; if (boot_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", boot_busy); end
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
        n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL single_hold: got %b want 0", core_rst_n); end
        send_byte(8'h00);
        n_cmp++; if (imem_we !== 1'b1) begin n_bad++; $display("FAIL single_we_pulse: got %b want 1", imem_we); end
`ifdef BOOT_CHECKSUM_EN
        n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL single_hold_csum: got %b want 0", core_rst_n); end
        send_byte(8'h12);
`endif
        n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL single_release: got %b want 1", core_rst_n); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL single_rx_ready: got %b want 0", rx_ready); end
        n_cmp++; if (words_loaded !== 9'd1) begin n_bad++; $display("FAIL single_words: got %0d want 1", words_loaded); end
        n_cmp++; if (boot_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_done: got %b want 0", boot_busy); end
        idle(3);
        n_cmp++; if (wr_cnt - base !== 1) begin n_bad++; $display("FAIL single_wr_count: got %0d want 1", wr_cnt - base); end
        n_cmp++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h00000013) begin n_bad++; $display("FAIL single_wr: got %h/%h want 00/00000013", wr_addr[base], wr_data[base]); end
        n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL single_stay_done: got %b want 1", core_rst_n); end
    endtask

    task automatic test_gaps();
        int base;
        do_reset();
        base = wr_cnt;
        img[0] = 32'h00500093;
        img[1] = 32'h00A00113;
        send_frame(2, 1'b1);
        n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL gaps_wr_count: got %0d want 2", wr_cnt - base); end
        n_cmp++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h00500093) begin n_bad++; $display("FAIL gaps_wr0: got %h/%h want 00/00500093", wr_addr[base], wr_data[base]); end
        n_cmp++; if (wr_addr[base+1] !== 8'h01 || wr_data[base+1] !== 32'h00A00113) begin n_bad++; $display("FAIL gaps_wr1: got %h/%h want 01/00a00113", wr_addr[base+1], wr_data[base+1]); end
        n_cmp++; if (core_rst_n !== 1'b1 || words_loaded !== 9'd2) begin n_bad++; $display("FAIL gaps_release: rst_n=%b words=%0d want 1/2", core_rst_n, words_loaded); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_bad_csum();
        int base;
        logic [7:0] x;
        do_reset();
        base = wr_cnt;
        img[0] = 32'h00500093;
        img[1] = 32'h00A00113;
        send_body(2, 1'b0, x);
        n_cmp++; if (x !== 8'h73) begin n_bad++; $display("FAIL csum_model: got %h want 73", x); end
        send_byte(x ^ 8'h01);
        n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL badcsum_wr_count: got %0d want 2", wr_cnt - base); end
        n_cmp++; if (boot_err !== 1'b1 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL badcsum_err: err=%b rst_n=%b want 1/0", boot_err, core_rst_n); end
        n_cmp++; if (rx_ready !== 1'b1 || words_loaded !== 9'd2) begin n_bad++; $display("FAIL badcsum_state: rdy=%b words=%0d want 1/2", rx_ready, words_loaded); end
        send_byte(8'h00); send_byte(8'hFF);
        n_cmp++; if (boot_err !== 1'b1 || boot_busy !== 1'b0) begin n_bad++; $display("FAIL badcsum_garbage: err=%b busy=%b want 1/0", boot_err, boot_busy); end
        send_frame(2, 1'b0);
        n_cmp++; if (boot_err !== 1'b0 || core_rst_n !== 1'b1) begin n_bad++; $display("FAIL badcsum_recover: err=%b rst_n=%b want 0/1", boot_err, core_rst_n); end
        n_cmp++; if (wr_cnt - base !== 4) begin n_bad++; $display("FAIL badcsum_rewrite: got %0d want 4", wr_cnt - base); end
    endtask
`endif

    task automatic test_bad_len();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        n_cmp++; if (boot_busy !== 1'b0 || boot_err !== 1'b0) begin n_bad++; $display("FAIL len_idle_garbage: busy=%b err=%b want 0/0", boot_busy, boot_err); end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        n_cmp++; if (boot_err !== 1'b1 || boot_busy !== 1'b0) begin n_bad++; $display("FAIL len_zero: err=%b busy=%b want 1/0", boot_err, boot_busy); end
        send_byte(8'h00); send_byte(8'hFF);
        n_cmp++; if (boot_err !== 1'b1 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL len_err_garbage: err=%b rdy=%b want 1/1", boot_err, rx_ready); end
        send_byte(8'hA5);
        n_cmp++; if (boot_err !== 1'b0 || boot_busy !== 1'b1) begin n_bad++; $display("FAIL len_err_exit: err=%b busy=%b want 0/1", boot_err, boot_busy); end
        send_byte(8'h01); send_byte(8'h01);
        n_cmp++; if (boot_err !== 1'b1 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL len_257: err=%b rst_n=%b want 1/0", boot_err, core_rst_n); end
        idle(2);
        n_cmp++; if (wr_cnt - base !== 0 || words_loaded !== 9'd0) begin n_bad++; $display("FAIL len_no_write: writes=%0d words=%0d want 0/0", wr_cnt - base, words_loaded); end
    endtask

    task automatic test_rst_midframe();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_we !== 1'b0 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: we=%b rst_n=%b want 0/0", imem_we, core_rst_n); end
        n_cmp++; if (boot_busy !== 1'b0 || rx_ready !== 1'b1 || words_loaded !== 9'd0) begin n_bad++; $display("FAIL midrst_state: busy=%b rdy=%b words=%0d want 0/1/0", boot_busy, rx_ready, words_loaded); end
        idle(2);
        rst = 1'b1;
        idle(3);
        n_cmp++; if (wr_cnt - base !== 1 || wr_data[base] !== 32'h44332211) begin n_bad++; $display("FAIL midrst_writes: n=%0d d=%h want 1/44332211", wr_cnt - base, wr_data[base]); end
        img[0] = 32'hDEADBEEF;
        send_frame(1, 1'b0);
        n_cmp++; if (wr_cnt - base !== 2 || wr_addr[base+1] !== 8'h00 || wr_data[base+1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL midrst_fresh: n=%0d a=%h d=%h want 2/00/deadbeef", wr_cnt - base, wr_addr[base+1], wr_data[base+1]); end
        n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL midrst_release: got %b want 1", core_rst_n); end
    endtask

    task automatic test_max_words();
        int base;
        int seq_err;
        do_reset();
        base = wr_cnt;
        for (int i = 0; i < 256; i++) img[i] = {8'(i), 8'(255 - i), 8'(i * 3), 8'(i + 7)};
        send_frame(256, 1'b0);
        seq_err = 0;
        for (int i = 0; i < 256; i++)
            if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== img[i]) seq_err++;
        n_cmp++; if (wr_cnt - base !== 256) begin n_bad++; $display("FAIL max_wr_count: got %0d want 256", wr_cnt - base); end
        n_cmp++; if (seq_err !== 0) begin n_bad++; $display("FAIL max_wr_seq: got %0d bad writes want 0", seq_err); end
        n_cmp++; if (wr_addr[base+255] !== 8'hFF || wr_data[base+255] !== 32'hFF00FD06) begin n_bad++; $display("FAIL max_last_wr: got %h/%h want ff/ff00fd06", wr_addr[base+255], wr_data[base+255]); end
        n_cmp++; if (words_loaded !== 9'd256 || core_rst_n !== 1'b1) begin n_bad++; $display("FAIL max_release: words=%0d rst_n=%b want 256/1", words_loaded, core_rst_n); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
`ifdef BOOT_CHECKSUM_EN
        test_bad_csum();
`endif
        test_bad_len();
        test_rst_midframe();
        test_max_words();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32_boot_loader.md
# rv32_boot_loader

Byte-stream program loader that sits directly upstream of the RV32 single-cycle core. It receives a framed program image, assembles little-endian 32-bit words, and writes them into instruction memory from word address 0. It holds the core in reset until a complete, valid image has been written. The system reset releases the loader, and the loader releases the core.

## Interface
- ADDR_W, 8, instruction-memory word-address width; MAX_WORDS = 2**ADDR_W
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader can accept a byte; transfer occurs on a clk edge with rx_valid & rx_ready
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  word to write
- core_rst_n  out  1  active-low reset to RV32 core
- boot_busy  out  1  frame in progress (states LEN0..CSUM)
- boot_err  out  1  last frame rejected
- words_loaded  out  ADDR_W+1  words written in the current/last frame

## Operation
- Frame: magic 0xA5, LEN_LO, LEN_HI (word count N, 16-bit LE), 4·N data bytes (LE per word), CSUM.
- CSUM = XOR of LEN_LO, LEN_HI and all data bytes.
- States:
  - IDLE: bytes other than 0xA5 are discarded; 0xA5 goes to LEN0.
  - LEN0: latch LEN_LO, go to LEN1.
  - LEN1: latch LEN_HI. If N==0 or N>MAX_WORDS, go to ERROR; otherwise go to DATA.
  - DATA: a 2-bit byte counter assembles words LSB first. On the 4th byte, issue a write at address = word index and increment words_loaded. After word N, go to CSUM.
  - CSUM: match goes to DONE; mismatch goes to ERROR.
  - DONE: core_rst_n=1, rx_ready=0. Only rst exits DONE.
  - ERROR: boot_err=1, core_rst_n=0, rx_ready=1. Byte 0xA5 clears boot_err, zeroes words_loaded and enters LEN0. Other bytes are discarded.
- Entering LEN0 from any state zeroes words_loaded, the byte counter and the running XOR.
- rx_ready=1 in every state except DONE.
- boot_busy=1 in LEN0, LEN1, DATA and CSUM.
- Memory contents are never cleared. A rejected or aborted frame leaves partially written words in place.

## Timing
- Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, boot_busy=0, boot_err=0, words_loaded=0, state IDLE.
- imem_we, imem_addr, imem_wdata and core_rst_n are registered.
- imem_we is high for exactly the one cycle following the edge that accepts a word's 4th byte. imem_addr/imem_wdata are valid in that same cycle.
- core_rst_n rises in the cycle after the edge that accepts a matching CSUM. Write-to-release latency is the CSUM byte's arrival plus 1 cycle.
- Back-to-back bytes (rx_valid held high) are accepted every cycle. Write throughput is one word per 4 cycles. No stall is generated toward memory.
- rx_valid gaps of any length mid-frame are allowed; the loader has no timeout.
- Asserting rst mid-frame:
  - immediately drives core_rst_n=0 and imem_we=0;
  - returns the loader to IDLE;
  - discards the partial word.
- N==MAX_WORDS is legal: the last write goes to address MAX_WORDS-1, and words_loaded reads MAX_WORDS.

## Configuration
- BOOT_CHECKSUM_EN defined: a CSUM byte is expected and checked exactly as above.
- BOOT_CHECKSUM_EN undefined: there is no CSUM byte and the running-XOR logic is absent. After word N the loader goes straight to DONE, and core_rst_n rises in the cycle after the edge accepting the last data byte. Without the checksum, ERROR is reachable only through an invalid N.

## Test plan
- Reset, then frame A5 01 00 13 00 00 00 CSUM=0x12 sent back-to-back:
  - one imem_we pulse with addr 0, wdata 0x00000013;
  - core_rst_n=1 one cycle after CSUM;
  - words_loaded=1 and rx_ready=0.
- Frame N=2, words 0x00500093 and 0x00A00113, with correct CSUM and random rx_valid gaps: writes at addr 0 and 1 with those values, then release.
- Same frame with CSUM XOR 0x01:
  - both words are written, then boot_err=1 and core_rst_n stays 0;
  - a following correct frame clears boot_err and releases the core.
- LEN=0x0000, and separately LEN=0x0101 with ADDR_W=8: ERROR after LEN_HI with no imem_we. Garbage bytes 0x00/0xFF in ERROR and IDLE are ignored.
- rst pulled low after 2 data bytes of word 1: imem_we stays 0 and the loader returns to reset values. A fresh frame writes from addr 0.
- N=256 at ADDR_W=8: the last write is at addr 0xFF, words_loaded=256, then release. With BOOT_CHECKSUM_EN undefined, repeat the N=1 case without CSUM; release occurs the cycle after the 4th data byte.
